// File: rtl/bomb_timer.sv
// Countdown timer for the bomb game: BCD M:SS display, strike-accelerated seconds,
// freezes on game over/defuse and flags explosion when the display reaches 0:00.
module bomb_timer #(
    parameter int unsigned CLK_HZ    = 27000000,
    parameter int unsigned START_MIN = 5,
    parameter int unsigned START_SEC = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] strikes,
    input  logic       freeze,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       tick,
    output logic       running,
    output logic       explode_timer
);

    localparam int unsigned CNT_W = $clog2(CLK_HZ);

    // Terminal count values (L-1); each is below CLK_HZ so fits in CNT_W bits.
    localparam logic [CNT_W-1:0] LAST_S0 = CNT_W'(CLK_HZ - 1);
    localparam logic [CNT_W-1:0] LAST_S1 = CNT_W'((3 * CLK_HZ) / 4 - 1);
    localparam logic [CNT_W-1:0] LAST_S2 = CNT_W'(CLK_HZ / 2 - 1);

    localparam logic [3:0] START_M_D = 4'(START_MIN);
    localparam logic [3:0] START_T_D = 4'(START_SEC / 10);
    localparam logic [3:0] START_O_D = 4'(START_SEC % 10);
    localparam logic       START_ZERO = (START_MIN == 0) && (START_SEC == 0);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FROZEN,
        EXPIRED
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] count, count_next;
    logic [CNT_W-1:0] last;
    logic [3:0]       min_next, tens_next, ones_next;
    logic [3:0]       dec_min, dec_tens, dec_ones;
    logic             dec_zero;
    logic             tick_next, explode_next;

    // Strike count 3 behaves as 2.
    always_comb begin
        case (strikes)
            2'd0:    last = LAST_S0;
            2'd1:    last = LAST_S1;
            default: last = LAST_S2;
        endcase
    end

    // One-second BCD decrement with borrow; clamps at 0:00.
    always_comb begin
        dec_ones = sec_ones - 4'd1;
        dec_tens = sec_tens;
        dec_min  = min_ones;
        if (sec_ones == 4'd0) begin
            dec_ones = 4'd9;
            if (sec_tens == 4'd0) begin
                dec_tens = 4'd5;
                dec_min  = (min_ones == 4'd0) ? 4'd0 : min_ones - 4'd1;
            end else begin
                dec_tens = sec_tens - 4'd1;
            end
        end
        if ((min_ones == 4'd0) && (sec_tens == 4'd0) && (sec_ones == 4'd0)) begin
            dec_min  = 4'd0;
            dec_tens = 4'd0;
            dec_ones = 4'd0;
        end
        dec_zero = (dec_min == 4'd0) && (dec_tens == 4'd0) && (dec_ones == 4'd0);
    end

    // Next-state and next-output logic.
    always_comb begin
        state_next   = state;
        count_next   = '0;
        min_next     = min_ones;
        tens_next    = sec_tens;
        ones_next    = sec_ones;
        tick_next    = 1'b0;
        explode_next = explode_timer;

        case (state)
            IDLE: begin
                if (start) begin
                    if (freeze) begin
                        state_next = FROZEN;
                    end else if (START_ZERO) begin
                        state_next   = EXPIRED;
                        explode_next = 1'b1;
                    end else begin
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                if (freeze) begin
                    state_next = FROZEN;
                end else if (count >= last) begin
                    min_next  = dec_min;
                    tens_next = dec_tens;
                    ones_next = dec_ones;
                    tick_next = 1'b1;
                    if (dec_zero) begin
                        state_next   = EXPIRED;
                        explode_next = 1'b1;
                    end
                end else begin
                    count_next = count + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            count         <= '0;
            min_ones      <= START_M_D;
            sec_tens      <= START_T_D;
            sec_ones      <= START_O_D;
            tick          <= 1'b0;
            running       <= 1'b0;
            explode_timer <= 1'b0;
        end else begin
            state         <= state_next;
            count         <= count_next;
            min_ones      <= min_next;
            sec_tens      <= tens_next;
            sec_ones      <= ones_next;
            tick          <= tick_next;
            running       <= (state_next == RUN);
            explode_timer <= explode_next;
        end
    end

endmodule

// File: tb/tb_bomb_timer.sv
// Runs three timers (0:02, 1:00, 0:00) on shared inputs against a seconds-based model.
module tb_bomb_timer;

    localparam int unsigned HZ = 8;
    localparam int N = 3;
    localparam int START_M [N] = '{0, 1, 0};
    localparam int START_S [N] = '{2, 0, 0};

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       freeze = 1'b0;
    logic [1:0] strikes = 2'd0;

    logic [3:0] min_ones [N];
    logic [3:0] sec_tens [N];
    logic [3:0] sec_ones [N];
    logic       tick [N];
    logic       running [N];
    logic       explode_timer [N];

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // Model: 0 idle, 1 run, 2 frozen, 3 expired; time kept as plain seconds.
    int m_mode [N];
    int m_count [N];
    int m_secs [N];
    bit m_tick [N];
    bit m_explode [N];

    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_dut
            bomb_timer #(
                .CLK_HZ   (HZ),
                .START_MIN(START_M[g]),
                .START_SEC(START_S[g])
            ) u_dut (
                .clock        (clock),
                .reset        (reset),
                .start        (start),
                .strikes      (strikes),
                .freeze       (freeze),
                .min_ones     (min_ones[g]),
                .sec_tens     (sec_tens[g]),
                .sec_ones     (sec_ones[g]),
                .tick         (tick[g]),
                .running      (running[g]),
                .explode_timer(explode_timer[g])
            );
        end
    endgenerate

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int limit_of(input logic [1:0] s);
        if (s == 2'd0) return HZ;
        if (s == 2'd1) return (3 * HZ) / 4;
        return HZ / 2;
    endfunction

    task automatic model_step();
        for (int i = 0; i < N; i++) begin
            m_tick[i] = 1'b0;
            if (reset) begin
                m_mode[i]    = 0;
                m_count[i]   = 0;
                m_secs[i]    = START_M[i] * 60 + START_S[i];
                m_explode[i] = 1'b0;
            end else if (m_mode[i] == 0) begin
                if (start) begin
                    if (freeze) m_mode[i] = 2;
                    else if (m_secs[i] == 0) begin
                        m_mode[i]    = 3;
                        m_explode[i] = 1'b1;
                    end else begin
                        m_mode[i]  = 1;
                        m_count[i] = 0;
                    end
                end
            end else if (m_mode[i] == 1) begin
                if (freeze) begin
                    m_mode[i] = 2;
                end else if (m_count[i] >= limit_of(strikes) - 1) begin
                    m_count[i] = 0;
                    m_secs[i]--;
                    m_tick[i] = 1'b1;
                    if (m_secs[i] == 0) begin
                        m_mode[i]    = 3;
                        m_explode[i] = 1'b1;
                    end
                end else begin
                    m_count[i]++;
                end
            end
        end
    endtask

    task automatic compare_all();
        logic [31:0] got, exp;
        for (int i = 0; i < N; i++) begin
            got = {17'd0, min_ones[i], sec_tens[i], sec_ones[i],
                   tick[i], running[i], explode_timer[i]};
            exp = {17'd0, 4'(m_secs[i] / 60), 4'((m_secs[i] % 60) / 10), 4'(m_secs[i] % 10),
                   m_tick[i], (m_mode[i] == 1), m_explode[i]};
            check($sformatf("out%0d", i), got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        model_step();
        #1;
        compare_all();
        cyc++;
    endtask

    function automatic logic [31:0] digits(input int i);
        return {20'd0, min_ones[i], sec_tens[i], sec_ones[i]};
    endfunction

    initial begin
        step();
        step();
        check("rst_digits1", digits(1), 32'h100);
        check("rst_explode0", 32'(explode_timer[0]), 32'd0);
        reset = 1'b0;

        // Basic countdown from 0:02 / 1:00, immediate expiry for 0:00.
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_running0", 32'(running[0]), 32'd1);
        check("zero_explode2", 32'(explode_timer[2]), 32'd1);
        check("zero_tick2", 32'(tick[2]), 32'd0);
        repeat (7) step();
        check("pre_tick1", 32'(tick[1]), 32'd0);
        step();
        check("tick1_at8", 32'(tick[1]), 32'd1);
        check("wrap_059", digits(1), 32'h059);
        check("dig0_at8", digits(0), 32'h001);
        repeat (8) step();
        check("explode0_at16", 32'(explode_timer[0]), 32'd1);
        check("dig0_at16", digits(0), 32'h000);
        check("run0_at16", 32'(running[0]), 32'd0);
        repeat (10) step();
        check("hold0", digits(0), 32'h000);
        check("zero_hold_tick2", 32'(tick[2]), 32'd0);

        // Freeze on the edge a tick is due.
        reset = 1'b1;
        step();
        reset = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (7) step();
        freeze = 1'b1;
        step();
        check("frz_digits", digits(1), 32'h100);
        check("frz_tick", 32'(tick[1]), 32'd0);
        check("frz_running", 32'(running[1]), 32'd0);
        freeze = 1'b0;
        start = 1'b1;
        repeat (3) step();
        start = 1'b0;
        repeat (10) step();
        check("frz_hold", digits(1), 32'h100);
        check("frz_explode", 32'(explode_timer[1]), 32'd0);

        // Strike changes: early tick on drop, then 6 and 4 cycle spacing.
        reset = 1'b1;
        step();
        reset = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        strikes = 2'd2;
        step();
        check("strike_early_tick", 32'(tick[1]), 32'd1);
        check("strike_early_dig", digits(1), 32'h059);
        strikes = 2'd1;
        repeat (18) step();
        strikes = 2'd3;
        repeat (12) step();
        check("strike_dig", digits(1), 32'h053);

        // Reset from EXPIRED (instance 0) and mid-second in RUN (instance 1).
        reset = 1'b1;
        step();
        check("rst_exp_dig0", digits(0), 32'h002);
        check("rst_exp_explode0", 32'(explode_timer[0]), 32'd0);
        check("rst_run_dig1", digits(1), 32'h100);
        check("rst_tick1", 32'(tick[1]), 32'd0);
        reset = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_mid_run1", 32'(running[1]), 32'd0);
        check("rst_mid_dig1", digits(1), 32'h100);

        // Randomized traffic against the model.
        for (int n = 0; n < 6000; n++) begin
            reset  = ($urandom_range(0, 499) == 0);
            start  = ($urandom_range(0, 19) == 0);
            freeze = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 9) == 0) strikes = 2'($urandom_range(0, 3));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bomb_timer.md
BOMB_TIMER -- requirements
Module: bomb_timer

Interface
REQ-001 Parameter CLK_HZ, default 27000000, clock cycles per nominal one-second tick; must be a multiple of 4 and at least 8.
REQ-002 Parameter START_MIN, default 5, starting minutes (0-9).
REQ-003 Parameter START_SEC, default 0, starting seconds (0-59).
REQ-004 clock  input  1  system clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  level; arms the countdown while in IDLE.
REQ-007 strikes  input  2  current strike count (0, 1 or 2); the value 3 is treated as 2.
REQ-008 freeze  input  1  level; halts the countdown (game over or bomb defused).
REQ-009 min_ones  output  4  BCD minutes digit.
REQ-010 sec_tens  output  4  BCD tens-of-seconds digit (0-5).
REQ-011 sec_ones  output  4  BCD seconds digit.
REQ-012 tick  output  1  one-cycle pulse on every displayed decrement.
REQ-013 running  output  1  high while in the RUN state.
REQ-014 explode_timer  output  1  sticky; high once the time reaches 0:00; feeds the game-over latch.

Function
REQ-015 The block shall implement four states: IDLE, RUN, FROZEN and EXPIRED.
REQ-016 IDLE -> RUN on the edge where start=1 and freeze=0; while in IDLE the digits hold START_MIN:START_SEC.
REQ-017 RUN -> FROZEN on any edge where freeze=1; freeze has priority over a tick due on the same edge, so no decrement occurs on that edge.
REQ-018 FROZEN shall be terminal until reset: digits hold, tick=0, running=0.
REQ-019 RUN -> EXPIRED on the tick edge that writes 0:00.
REQ-020 EXPIRED shall be terminal until reset: digits hold 0:00 and explode_timer=1.
REQ-021 In RUN, a prescaler shall count clock cycles up to a limit L, then wrap to 0 and decrement the digits.
REQ-022 The limit L depends on strikes: 0 strikes -> CLK_HZ, 1 strike -> 3*CLK_HZ/4, 2 strikes -> CLK_HZ/2.
REQ-023 The prescaler ticks when count >= L-1, so a mid-second drop in L ticks on the next edge.
REQ-024 The prescaler shall be held at 0 in IDLE, FROZEN and EXPIRED, and shall be cleared on entry to RUN.
REQ-025 The prescaler width shall be $clog2(CLK_HZ) bits, with no overflow for any legal parameter value.
REQ-026 Decrement rule, step 1: sec_ones 0 borrows -> 9 and sec_tens decrements.
REQ-027 Decrement rule, step 2: sec_tens 0 borrowing -> 5, and min_ones decrements.
REQ-028 Decrement rule, step 3: digits never leave the BCD range and never wrap below 0:00.
REQ-029 tick shall be high for exactly the one cycle after each decrementing edge (registered).
REQ-030 explode_timer shall be registered and shall rise on the same edge at which the digits become 0:00.
REQ-031 If START_MIN=0 and START_SEC=0, IDLE -> EXPIRED on start, with no tick.
REQ-032 If start and freeze are both high in IDLE, IDLE -> FROZEN.
REQ-033 Changes on strikes outside RUN shall have no effect.

Reset
REQ-034 When reset=1 at an edge, the block shall go to IDLE with prescaler=0, digits=START_MIN:START_SEC, tick=0, running=0 and explode_timer=0.
REQ-035 Reset shall override every other input, in any state, including in the middle of a second.

Verification
REQ-036 Use CLK_HZ=8, START=0:02, strikes=0; pulse start -> running=1; tick every 8 cycles; 0:02 -> 0:01 -> 0:00; explode_timer=1 16 cycles after start; digits hold afterwards.
REQ-037 Use CLK_HZ=8, START=1:00; after one tick, digits read 0:59 (sec_tens=5, sec_ones=9, min_ones=0).
REQ-038 Set strikes=1 then 2 during RUN -> tick spacing of 6, then 4 cycles; raising strikes from 0 to 2 when count=5 -> tick on the next edge.
REQ-039 Raise freeze on the same edge a tick is due -> no decrement, tick=0, running=0; further start pulses are ignored; explode_timer stays 0.
REQ-040 Assert reset in EXPIRED and again in the middle of RUN -> IDLE with the START digits, explode_timer=0 and tick=0 on the next cycle.
REQ-041 Use START=0:00 with a start pulse -> explode_timer=1 after one edge, and tick never asserts.
